// File: rtl/deserializer.sv
// Serial-to-parallel receiver: packs MSB-first bits into DATA_W words behind a one-entry valid/ready holding register.
// Optional DESER_FLUSH_EN adds flush_i/deser_mod_o to emit a left-aligned partial word.
module deserializer #(
   parameter  int DATA_W = 16,
   localparam int MOD_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              ser_data_i,
   input  logic              ser_data_val_i,
`ifdef DESER_FLUSH_EN
   input  logic              flush_i,
   output logic [MOD_W-1:0]  deser_mod_o,
`endif
   output logic [DATA_W-1:0] deser_data_o,
   output logic              deser_data_val_o,
   input  logic              deser_data_rdy_i,
   output logic              busy_o,
   output logic              overflow_o
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

   hold_state_t       state_reg;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_next;
   logic [MOD_W-1:0]  cnt_reg;
   logic [MOD_W-1:0]  cnt_next;
   logic [DATA_W-1:0] data_reg;
   logic              busy_reg;
   logic              overflow_reg;
   logic              complete;
   logic              emit;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] word_next;
`ifdef DESER_FLUSH_EN
   logic [MOD_W-1:0]  mod_reg;
   logic [MOD_W-1:0]  mod_next;
   logic [MOD_W:0]    n_bits;
`endif

   assign shifted  = {shift_reg[DATA_W-2:0], ser_data_i};
   assign complete = ser_data_val_i && (cnt_reg == MOD_W'(DATA_W - 1));

   always_comb begin
      shift_next = shift_reg;
      cnt_next   = cnt_reg;
      emit       = 1'b0;
      word_next  = shifted;
`ifdef DESER_FLUSH_EN
      mod_next   = '0;
      n_bits     = (MOD_W+1)'(cnt_reg) + (MOD_W+1)'(ser_data_val_i);
`endif
      if (ser_data_val_i) begin
         shift_next = shifted;
         // DATA_W is a power of two, so the counter wraps to 0 on completion
         cnt_next   = cnt_reg + MOD_W'(1);
      end
      if (complete) begin
         emit = 1'b1;
      end
`ifdef DESER_FLUSH_EN
      else if (flush_i && (n_bits != '0)) begin
         // Collected bits sit in the low n positions; shifting left drops stale upper bits
         emit       = 1'b1;
         word_next  = (ser_data_val_i ? shifted : shift_reg) << (DATA_W - int'(n_bits));
         mod_next   = n_bits[MOD_W-1:0];
         shift_next = '0;
         cnt_next   = '0;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg    <= EMPTY;
         shift_reg    <= '0;
         cnt_reg      <= '0;
         data_reg     <= '0;
         busy_reg     <= 1'b0;
         overflow_reg <= 1'b0;
`ifdef DESER_FLUSH_EN
         mod_reg      <= '0;
`endif
      end else begin
         shift_reg    <= shift_next;
         cnt_reg      <= cnt_next;
         busy_reg     <= (cnt_next != '0);
         overflow_reg <= 1'b0;
         case (state_reg)
            EMPTY: begin
               if (emit) begin
                  state_reg <= FULL;
                  data_reg  <= word_next;
`ifdef DESER_FLUSH_EN
                  mod_reg   <= mod_next;
`endif
               end
            end
            FULL: begin
               if (deser_data_rdy_i) begin
                  if (emit) begin
                     data_reg <= word_next;
`ifdef DESER_FLUSH_EN
                     mod_reg  <= mod_next;
`endif
                  end else begin
                     state_reg <= EMPTY;
                  end
               end else if (emit) begin
                  // Held word wins; the new one is lost and flagged
                  overflow_reg <= 1'b1;
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end

   assign deser_data_o     = data_reg;
   assign deser_data_val_o = (state_reg == FULL);
   assign busy_o           = busy_reg;
   assign overflow_o       = overflow_reg;
`ifdef DESER_FLUSH_EN
   assign deser_mod_o      = mod_reg;
`endif

endmodule
